// File: rtl/cpu_eu_if.sv
// Control-word and memory-bus bundle between the CPU control unit and the execution unit.
// No handshake: the control word is sampled on every rising clk edge, and results are valid combinationally in the same cycle.
interface cpu_eu_if;
  logic [2:0]  W_addr;
  logic [2:0]  R_addr;
  logic [2:0]  S_addr;
  logic        adr_sel;
  logic        s_sel;
  logic        pc_ld;
  logic        pc_inc;
  logic        pc_sel;
  logic        ir_ld;
  logic        rw_en;
  logic [3:0]  alu_op;
  logic [15:0] D_in;
  logic [15:0] Address;
  logic [15:0] D_out;
  logic [15:0] IR;
  logic        N;
  logic        Z;
  logic        C;

  modport master (
    output W_addr, R_addr, S_addr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
           ir_ld, rw_en, alu_op, D_in,
    input  Address, D_out, IR, N, Z, C
  );

  modport slave (
    input  W_addr, R_addr, S_addr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
           ir_ld, rw_en, alu_op, D_in,
    output Address, D_out, IR, N, Z, C
  );
endinterface

// File: rtl/cpu_eu.sv
// 16-bit CPU execution unit: PC, IR, 8x16 register file and ALU.
// Optional macro EU_R0_ZERO_EN hardwires R0 to zero.
module cpu_eu (
  input  logic     clk,
  input  logic     reset,
  cpu_eu_if.slave  eu_io
);
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] rf_q [8];
  logic [15:0] r_out, s_out, y, wdata;
  logic [16:0] sum;
  logic        c;
  logic        wr_ok;

`ifdef EU_R0_ZERO_EN
  assign r_out = (eu_io.R_addr == 3'd0) ? 16'h0000 : rf_q[eu_io.R_addr];
  assign s_out = (eu_io.S_addr == 3'd0) ? 16'h0000 : rf_q[eu_io.S_addr];
  assign wr_ok = eu_io.rw_en && (eu_io.W_addr != 3'd0);
`else
  assign r_out = rf_q[eu_io.R_addr];
  assign s_out = rf_q[eu_io.S_addr];
  assign wr_ok = eu_io.rw_en;
`endif

  // Arithmetic ops run in 17 bits so the carry/borrow falls out as bit 16.
  always_comb begin
    y   = 16'h0000;
    c   = 1'b0;
    sum = 17'h00000;
    case (eu_io.alu_op)
      4'b0000: y = s_out;
      4'b0001: y = r_out;
      4'b0010: begin sum = {1'b0, s_out} + 17'd1;          {c, y} = sum; end
      4'b0011: begin sum = {1'b0, s_out} - 17'd1;          {c, y} = sum; end
      4'b0100: begin sum = {1'b0, r_out} + {1'b0, s_out};  {c, y} = sum; end
      4'b0101: begin sum = {1'b0, r_out} - {1'b0, s_out};  {c, y} = sum; end
      4'b0110: begin y = {1'b0, s_out[15:1]}; c = s_out[0];  end
      4'b0111: begin y = {s_out[14:0], 1'b0}; c = s_out[15]; end
      default: ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (eu_io.pc_ld)
      pc_d = eu_io.pc_sel ? s_out : pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
    else if (eu_io.pc_inc)
      pc_d = pc_q + 16'd1;
  end

  assign ir_d  = eu_io.ir_ld ? eu_io.D_in : ir_q;
  assign wdata = eu_io.s_sel ? eu_io.D_in : y;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 16'h0000;
      ir_q <= 16'h0000;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      if (wr_ok) rf_q[eu_io.W_addr] <= wdata;
    end
  end

  assign eu_io.Address = eu_io.adr_sel ? r_out : pc_q;
  assign eu_io.D_out   = s_out;
  assign eu_io.IR      = ir_q;
  assign eu_io.N       = y[15];
  assign eu_io.Z       = (y == 16'h0000);
  assign eu_io.C       = c;
endmodule

// File: tb/tb_cpu_eu.sv
// Bench for cpu_eu: directed control-word sequences plus random words, checked against an arithmetic model.
module tb_cpu_eu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_eu_if bus ();
  cpu_eu dut (.clk(clk), .reset(reset), .eu_io(bus));

  typedef struct {
    logic       rst;
    logic [2:0] w, r, s;
    logic       adr, ssel, pcld, pcinc, pcsel, irld, rw;
    logic [3:0] op;
    logic [15:0] din;
  } cw_t;

  logic [15:0] m_pc, m_ir;
  logic [15:0] m_rf [8];
  logic [15:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

`ifdef EU_R0_ZERO_EN
  localparam logic [15:0] R0_EXP = 16'h0000;
`else
  localparam logic [15:0] R0_EXP = 16'h1111;
`endif

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
`ifdef EU_R0_ZERO_EN
    if (a == 3'd0) return 16'h0000;
`endif
    return m_rf[a];
  endfunction

  task automatic m_alu(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s,
                       output logic [15:0] y, output logic c);
    int t;
    y = 16'h0000; c = 1'b0;
    case (op)
      4'd0: y = s;
      4'd1: y = r;
      4'd2: begin t = int'(s) + 1;       y = 16'(t); c = (t > 65535); end
      4'd3: begin t = int'(s) - 1;       y = 16'(t); c = (s == 16'h0000); end
      4'd4: begin t = int'(r) + int'(s); y = 16'(t); c = (t > 65535); end
      4'd5: begin t = int'(r) - int'(s); y = 16'(t); c = (r < s); end
      4'd6: begin y = s / 2; c = (s % 2) != 0; end
      4'd7: begin t = int'(s) * 2;       y = 16'(t); c = (s >= 16'h8000); end
      default: ;
    endcase
  endtask

  function automatic cw_t idle();
    cw_t cw;
    cw.rst = 0; cw.w = 0; cw.r = 0; cw.s = 0; cw.adr = 0; cw.ssel = 0;
    cw.pcld = 0; cw.pcinc = 0; cw.pcsel = 0; cw.irld = 0; cw.rw = 0;
    cw.op = 0; cw.din = 0;
    return cw;
  endfunction

  // Drive one control word at the falling edge, check outputs, then advance the model past the next rising edge.
  task automatic step(input cw_t cw, input string name);
    logic [15:0] rv, sv, y, wd;
    logic c;
    int off;
    @(negedge clk);
    reset = cw.rst;
    bus.W_addr = cw.w; bus.R_addr = cw.r; bus.S_addr = cw.s;
    bus.adr_sel = cw.adr; bus.s_sel = cw.ssel; bus.pc_ld = cw.pcld;
    bus.pc_inc = cw.pcinc; bus.pc_sel = cw.pcsel; bus.ir_ld = cw.irld;
    bus.rw_en = cw.rw; bus.alu_op = cw.op; bus.D_in = cw.din;
    #1;
    rv = m_read(cw.r);
    sv = m_read(cw.s);
    m_alu(cw.op, rv, sv, y, c);
    exp_q.push_back(cw.adr ? rv : m_pc);
    exp_q.push_back(sv);
    exp_q.push_back(m_ir);
    exp_q.push_back({15'd0, y[15]});
    exp_q.push_back({15'd0, y == 16'h0000});
    exp_q.push_back({15'd0, c});
    check_val({name, ".address"}, bus.Address, exp_q.pop_front());
    check_val({name, ".d_out"},   bus.D_out,   exp_q.pop_front());
    check_val({name, ".ir"},      bus.IR,      exp_q.pop_front());
    check_val({name, ".n"}, {15'd0, bus.N}, exp_q.pop_front());
    check_val({name, ".z"}, {15'd0, bus.Z}, exp_q.pop_front());
    check_val({name, ".c"}, {15'd0, bus.C}, exp_q.pop_front());
    if (cw.rst) begin
      m_pc = 0; m_ir = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
    end else begin
      wd = cw.ssel ? cw.din : y;
      if (cw.pcld) begin
        off = int'(m_ir[7:0]);
        if (off >= 128) off = off - 256;
        m_pc = cw.pcsel ? sv : 16'(int'(m_pc) + off);
      end else if (cw.pcinc) begin
        m_pc = 16'(int'(m_pc) + 1);
      end
      if (cw.irld) m_ir = cw.din;
`ifdef EU_R0_ZERO_EN
      if (cw.rw && cw.w != 3'd0) m_rf[cw.w] = wd;
`else
      if (cw.rw) m_rf[cw.w] = wd;
`endif
    end
  endtask

  task automatic probe(input logic [2:0] r, input logic [2:0] s, input logic adr);
    cw_t cw;
    cw = idle(); cw.r = r; cw.s = s; cw.adr = adr;
    step(cw, "probe");
  endtask

  task automatic fetch(input logic [15:0] din);
    cw_t cw;
    cw = idle(); cw.irld = 1; cw.pcinc = 1; cw.din = din;
    step(cw, "fetch");
  endtask

  task automatic ldi(input logic [2:0] w, input logic [15:0] din);
    cw_t cw;
    cw = idle(); cw.ssel = 1; cw.pcinc = 1; cw.rw = 1; cw.w = w; cw.din = din;
    step(cw, "ldi");
  endtask

  initial begin
    cw_t cw;
    reset = 1'b1;
    bus.W_addr = 0; bus.R_addr = 0; bus.S_addr = 0; bus.adr_sel = 0; bus.s_sel = 0;
    bus.pc_ld = 0; bus.pc_inc = 0; bus.pc_sel = 0; bus.ir_ld = 0; bus.rw_en = 0;
    bus.alu_op = 0; bus.D_in = 0;
    repeat (2) @(posedge clk);
    m_pc = 0; m_ir = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;

    probe(0, 0, 0);
    check_val("rst.address", bus.Address, 16'h0000);
    check_val("rst.d_out", bus.D_out, 16'h0000);
    check_val("rst.ir", bus.IR, 16'h0000);
    check_val("rst.nzc", {13'd0, bus.N, bus.Z, bus.C}, 16'h0002);

    fetch(16'hE0D1);
    check_val("fetch.addr_during", bus.Address, 16'h0000);
    probe(0, 0, 0);
    check_val("fetch.ir", bus.IR, 16'hE0D1);
    check_val("fetch.pc", bus.Address, 16'h0001);

    ldi(1, 16'h7FFF);
    ldi(2, 16'h0001);
    cw = idle(); cw.w = 3; cw.r = 1; cw.s = 2; cw.op = 4'd4; cw.rw = 1;
    step(cw, "add");
    check_val("add.nzc", {13'd0, bus.N, bus.Z, bus.C}, 16'h0004);
    probe(0, 3, 0);
    check_val("add.r3", bus.D_out, 16'h8000);

    ldi(4, 16'h0003);
    ldi(5, 16'h0005);
    cw = idle(); cw.w = 7; cw.r = 4; cw.s = 5; cw.op = 4'd5; cw.rw = 1;
    step(cw, "sub");
    check_val("sub.nc", {14'd0, bus.N, bus.C}, 16'h0003);
    probe(0, 7, 0);
    check_val("sub.y", bus.D_out, 16'hFFFE);

    cw = idle(); cw.w = 7; cw.s = 0; cw.op = 4'd3; cw.rw = 1;
    step(cw, "dec");
    check_val("dec.c", {15'd0, bus.C}, 16'h0001);
    probe(0, 7, 0);
    check_val("dec.y", bus.D_out, 16'hFFFF);

    cw = idle(); cw.s = 7; cw.op = 4'd2;
    step(cw, "inc");
    check_val("inc.zc", {14'd0, bus.Z, bus.C}, 16'h0003);

    ldi(6, 16'h000F);
    cw = idle(); cw.pcld = 1; cw.pcsel = 1; cw.s = 6;
    step(cw, "jmp");
    fetch(16'h00FC);
    probe(0, 0, 0);
    check_val("br.pc_before", bus.Address, 16'h0010);
    cw = idle(); cw.pcld = 1;
    step(cw, "branch");
    probe(0, 0, 0);
    check_val("br.pc_after", bus.Address, 16'h000C);

    ldi(6, 16'h1234);
    cw = idle(); cw.pcld = 1; cw.pcsel = 1; cw.pcinc = 1; cw.s = 6;
    step(cw, "ld_wins");
    probe(0, 0, 0);
    check_val("ld_wins.pc", bus.Address, 16'h1234);

    ldi(4, 16'h0040);
    ldi(5, 16'hBEEF);
    cw = idle(); cw.adr = 1; cw.r = 4; cw.s = 5;
    step(cw, "sto");
    check_val("sto.address", bus.Address, 16'h0040);
    check_val("sto.d_out", bus.D_out, 16'hBEEF);
    cw = idle(); cw.adr = 1; cw.r = 4; cw.ssel = 1; cw.rw = 1; cw.w = 6; cw.din = 16'h55AA;
    step(cw, "load");
    probe(0, 6, 0);
    check_val("load.r6", bus.D_out, 16'h55AA);

    cw = idle(); cw.rw = 1; cw.w = 0; cw.ssel = 1; cw.din = 16'h1111;
    step(cw, "wr_r0");
    probe(0, 0, 1);
    check_val("r0.port_r", bus.Address, R0_EXP);
    check_val("r0.port_s", bus.D_out, R0_EXP);

    cw = idle(); cw.rst = 1; cw.rw = 1; cw.w = 1; cw.ssel = 1; cw.din = 16'hABCD;
    cw.pcinc = 1; cw.irld = 1;
    step(cw, "mid_reset");
    probe(1, 1, 0);
    check_val("mid_reset.pc", bus.Address, 16'h0000);
    check_val("mid_reset.r1", bus.D_out, 16'h0000);
    check_val("mid_reset.ir", bus.IR, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      cw.rst   = ($urandom_range(0, 39) == 0);
      cw.w     = 3'($urandom_range(0, 7));
      cw.r     = 3'($urandom_range(0, 7));
      cw.s     = 3'($urandom_range(0, 7));
      cw.adr   = 1'($urandom_range(0, 1));
      cw.ssel  = 1'($urandom_range(0, 1));
      cw.pcld  = ($urandom_range(0, 3) == 0);
      cw.pcinc = 1'($urandom_range(0, 1));
      cw.pcsel = 1'($urandom_range(0, 1));
      cw.irld  = 1'($urandom_range(0, 1));
      cw.rw    = 1'($urandom_range(0, 1));
      cw.op    = 4'($urandom_range(0, 15));
      cw.din   = 16'($urandom);
      step(cw, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
